// File: rtl/mem_arbiter.sv
// Shared memory port arbiter: I-cache fill, D-cache fill and write-through.
// Writes win in IDLE until the starve counter lets a waiting fill through.
module mem_arbiter #(
   parameter int WR_STARVE_LIMIT = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        i_req,
   input  logic        i_rd_en,
   input  logic [15:0] i_addr,
   input  logic        i_done,
   input  logic        d_req,
   input  logic        d_rd_en,
   input  logic [15:0] d_addr,
   input  logic        d_done,
   input  logic        wr_req,
   input  logic [15:0] wr_addr,
   input  logic [15:0] wr_data,
   input  logic        mem_data_valid,
   output logic        mem_enable,
   output logic        mem_wr,
   output logic [15:0] mem_addr,
   output logic [15:0] mem_data_in,
   output logic        i_grant,
   output logic        d_grant,
   output logic        wr_ack,
   output logic        i_data_valid,
   output logic        d_data_valid,
   output logic        i_stall,
   output logic        d_stall,
   output logic        arb_busy
);

   typedef enum logic [1:0] {
      IDLE,
      WRITE,
      IFILL,
      DFILL
   } state_t;

   localparam logic [2:0] LIMIT = 3'(WR_STARVE_LIMIT);

   state_t     r_state;
   logic       r_last_fill;
   logic [2:0] r_starve;
   logic       r_i_grant;
   logic       r_d_grant;
   logic       r_wr_ack;

   logic       w_fill_pend;
   logic       w_starved;
   logic       w_pick_d;
   logic [2:0] w_starve_inc;

   assign w_fill_pend  = i_req | d_req;
   assign w_starved    = (r_starve == LIMIT) && w_fill_pend;
   // On a tie, serve whichever side was not served last.
   assign w_pick_d     = d_req & (~i_req | ~r_last_fill);
   assign w_starve_inc = (r_starve == LIMIT) ? r_starve : r_starve + 3'd1;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state     <= IDLE;
         r_last_fill <= 1'b0;
         r_starve    <= 3'd0;
         r_i_grant   <= 1'b0;
         r_d_grant   <= 1'b0;
         r_wr_ack    <= 1'b0;
      end else begin
         unique case (r_state)
            IDLE: begin
               if (wr_req && !w_starved) begin
                  r_state  <= WRITE;
                  r_wr_ack <= 1'b1;
                  r_starve <= w_fill_pend ? w_starve_inc : 3'd0;
               end else if (w_fill_pend) begin
                  r_starve <= 3'd0;
                  if (w_pick_d) begin
                     r_state     <= DFILL;
                     r_d_grant   <= 1'b1;
                     r_last_fill <= 1'b1;
                  end else begin
                     r_state     <= IFILL;
                     r_i_grant   <= 1'b1;
                     r_last_fill <= 1'b0;
                  end
               end
            end
            WRITE: begin
               r_state  <= IDLE;
               r_wr_ack <= 1'b0;
            end
            IFILL: begin
               if (i_done) begin
                  r_state   <= IDLE;
                  r_i_grant <= 1'b0;
               end
            end
            DFILL: begin
               if (d_done) begin
                  r_state   <= IDLE;
                  r_d_grant <= 1'b0;
               end
            end
         endcase
      end
   end

   always_comb begin
      mem_enable  = 1'b0;
      mem_wr      = 1'b0;
      mem_addr    = 16'h0000;
      mem_data_in = 16'h0000;
      case (r_state)
         WRITE: begin
            mem_enable  = 1'b1;
            mem_wr      = 1'b1;
            mem_addr    = wr_addr;
            mem_data_in = wr_data;
         end
         IFILL: begin
            mem_enable = i_rd_en;
            mem_addr   = i_addr;
         end
         DFILL: begin
            mem_enable = d_rd_en;
            mem_addr   = d_addr;
         end
         default: ;
      endcase
   end

   assign i_grant      = r_i_grant;
   assign d_grant      = r_d_grant;
   assign wr_ack       = r_wr_ack;
   assign i_data_valid = mem_data_valid & (r_state == IFILL);
   assign d_data_valid = mem_data_valid & (r_state == DFILL);
   assign i_stall      = i_req & ~r_i_grant;
   assign d_stall      = (d_req & ~r_d_grant) | (wr_req & ~r_wr_ack);
   assign arb_busy     = (r_state != IDLE);

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter: WR_STARVE_LIMIT, default 4, number of consecutive write grants allowed while a fill request waits.
REQ-002 SHALL have ports (name direction width meaning):
- clk  input  1  single clock, all state updates on rising edge
- rst_n  input  1  synchronous active-low reset
- i_req  input  1  I-cache fill FSM requests the memory port
- i_rd_en  input  1  I-cache per-word read enable
- i_addr  input  16  I-cache word read address
- i_done  input  1  I-cache fill complete; its tag write pulse
- d_req  input  1  D-cache fill FSM requests the memory port
- d_rd_en  input  1  D-cache per-word read enable
- d_addr  input  16  D-cache word read address
- d_done  input  1  D-cache fill complete
- wr_req  input  1  D-cache write-through request
- wr_addr  input  16  write address
- wr_data  input  16  write data
- mem_data_valid  input  1  memory read data valid
- mem_enable  output  1  memory access enable
- mem_wr  output  1  memory write strobe
- mem_addr  output  16  memory address
- mem_data_in  output  16  memory write data
- i_grant  output  1  I-cache owns the port
- d_grant  output  1  D-cache fill owns the port
- wr_ack  output  1  write issued this cycle
- i_data_valid  output  1  mem_data_valid routed to I-cache
- d_data_valid  output  1  mem_data_valid routed to D-cache
- i_stall  output  1  i_req & ~i_grant
- d_stall  output  1  (d_req & ~d_grant) | (wr_req & ~wr_ack)
- arb_busy  output  1  state != IDLE
REQ-003 SHALL treat reset as synchronous and active-low on rst_n, sampled on clk rising edge; one clock domain only.

Function
REQ-004 SHALL implement four states: IDLE, WRITE, IFILL, DFILL. i_grant=1 iff IFILL; d_grant=1 iff DFILL; wr_ack=1 iff WRITE. All three are registered outputs.
REQ-005 SHALL evaluate requests only in IDLE; a request sampled in cycle N produces its grant or wr_ack in cycle N+1.
REQ-006 SHALL use IDLE priority: wr_req over fills, unless the write-starve counter equals WR_STARVE_LIMIT and a fill request is pending, in which case that fill wins.
REQ-007 SHALL arbitrate between i_req and d_req round-robin via a last_fill flag: when both are pending, grant the one not last served; when only one is pending, grant it.
REQ-008 SHALL make WRITE last exactly one cycle: mem_enable=1, mem_wr=1, mem_addr=wr_addr, mem_data_in=wr_data, wr_ack=1; next state IDLE.
REQ-009 SHALL forward in IFILL: mem_enable=i_rd_en, mem_wr=0, mem_addr=i_addr. DFILL forwards d_rd_en and d_addr the same way.
REQ-010 SHALL route mem_data_valid only to the owner: i_data_valid=mem_data_valid&IFILL, d_data_valid=mem_data_valid&DFILL; otherwise both are 0.
REQ-011 SHALL hold a fill grant until the owner's done is sampled high; next state IDLE, so the grant drops in the following cycle. The owner's req deasserting without done does not release the grant.
REQ-012 SHALL ignore the non-owner's done and all requests while in IFILL or DFILL.
REQ-013 SHALL update the write-starve counter (3 bits, saturating at WR_STARVE_LIMIT) as follows:
- +1 on each write grant while i_req|d_req is pending
- clear on any fill grant
- clear when a write is granted with no fill pending
REQ-014 SHALL drive mem_enable=0, mem_wr=0, mem_addr=0, mem_data_in=0 in IDLE.
REQ-015 SHALL have one idle bubble cycle minimum between consecutive grants; done and a new request in the same cycle release first and evaluate next cycle.
REQ-016 SHALL set last_fill on each fill grant (0=I, 1=D).

Reset
REQ-017 SHALL, when rst_n=0 at an edge:
- state=IDLE, last_fill=0 (D wins first tie), starve counter=0
- all registered outputs 0
REQ-018 SHALL abandon any in-progress fill or write on reset mid-operation; no grant reasserts until a request is sampled after rst_n returns high.

Verification
REQ-019 SHALL cover: i_req=d_req=1 from reset in IDLE -> d_grant=1 next cycle; after d_done, one IDLE cycle, then i_grant=1.
REQ-020 SHALL cover: wr_req and d_req together in IDLE, wr_addr=16'h1234, wr_data=16'hBEEF -> next cycle mem_wr=1, mem_addr=16'h1234, mem_data_in=16'hBEEF, wr_ack=1, d_stall=1.
REQ-021 SHALL cover: wr_req held high with i_req pending, limit 4 -> exactly 4 wr_ack pulses, then i_grant=1.
REQ-022 SHALL cover: DFILL with 8 mem_data_valid pulses, i_req=1 throughout -> d_data_valid pulses 8 times, i_data_valid stays 0, i_stall=1 until i_grant.
REQ-023 SHALL cover: rst_n=0 during IFILL after 3 words -> next cycle i_grant=0, mem_enable=0, arb_busy=0.
REQ-024 SHALL cover: in IFILL, i_req drops and d_done pulses -> i_grant stays 1 until i_done=1.
